i2c_controller: RTL and testbench
=================================

Name: i2c_controller

Overview:
- Single-byte I2C bus controller. It issues START, a 7-bit address frame plus R/W bit, one data byte (write or read) and STOP on an open-drain SCL/SDA pair.
- It drives transactions into the team's i2c_peripheral slaves and uses the same bit ordering and acknowledge conventions they use.
- A fabric-side command handshake starts each transaction and reports completion.

Parameters:
- CLK_DIV, 25, clk cycles per quarter SCL period. SCL period = 4*CLK_DIV clk cycles. Legal range is 2 or more.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  command strobe; sampled only when busy=0
- addr  input  7  target peripheral address
- rw  input  1  0 = controller writes wdata, 1 = controller reads rdata
- wdata  input  8  byte to write
- rdata  output  8  byte read; valid when done=1 and rw was 1
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when the transaction ends (after STOP)
- ack_error  output  1  set with done if any peripheral acknowledge slot read SDA=1; held until the next accepted start
- scl  inout  1  open-drain clock; driven 0 or released to z, never driven 1
- sda  inout  1  open-drain data; driven 0 or released to z, never driven 1

Behaviour:

Reset (async, reset_n=0):
- scl and sda released (z); state IDLE.
- busy=0, done=0, ack_error=0, rdata=8'h00.
- Reset mid-transaction aborts immediately. Lines are released with no STOP generated.

Bus input and timing:
- sda is sampled through a 2-flop synchronizer.
- A quarter-tick counter runs 0..CLK_DIV-1 only while busy. It restarts on each accepted start.
- Each bit occupies 4 quarters:
  - Q0: SCL low; SDA updated at Q0 entry.
  - Q1: SCL low.
  - Q2: SCL released high.
  - Q3: SCL high; synchronized SDA sampled at Q3 entry.
- Clock stretching is not supported. SCL is never read back.

Bit order and conventions (must match i2c_peripheral):
- LSB-first throughout.
- Address frame order: addr[0]..addr[6], then rw.
- Data bytes: bit 0 first.
- Acknowledge = SDA low in the 9th clock.

FSM states, in order:
- IDLE: lines released. On start with busy=0, latch addr/rw/wdata, clear ack_error, set busy, go to START.
- START: 1 quarter with SCL and SDA high, then SDA low for 2 quarters while SCL stays high, then go to ADDR.
- ADDR: 8 bits driven from the latched frame, via a 3-bit bit counter 0..7. Then AACK.
- AACK: SDA released for 1 bit; sample at Q3.
  - SDA=1 (NACK): set ack_error, go to STOP.
  - ACK with rw=0: go to WDATA.
  - ACK with rw=1: go to RDATA.
- WDATA: 8 bits of wdata, then WACK.
- WACK: SDA released; sample. A 1 sets ack_error. Go to STOP either way.
- RDATA: SDA released for 8 bits. At each Q3 shift the sample into rdata position equal to the bit counter; first bit goes to rdata[0]. Then RACK.
- RACK: controller drives SDA low for the 9th clock. This is the terminate code the peripheral requires to stop transmitting. Then STOP.
- STOP, 4 quarters:
  - SCL low, SDA low.
  - SCL high, SDA low.
  - SCL high, SDA released.
  - Bus-free quarter.
  - Then pulse done for 1 cycle, drop busy, return to IDLE.
- Driving 1 is realised as release (z) everywhere.

Handshake and boundary conditions:
- start while busy=1 is ignored. addr/rw/wdata changes after acceptance have no effect.
- start asserted in the same cycle as done is ignored. A new start is accepted from the cycle after done.
- rdata holds its value until the next read transaction's first sampled bit. It is not cleared on write transactions.
- SDA changes only while SCL is low, except the START and STOP edges.

Latency:
- Total from accepted start to done ≈ (3 + 4*(9+9) + 4) quarters.
- Bench checks within ±1 quarter.

Test Plan:
- Write, ACK: CLK_DIV=2, addr=7'h42, rw=0, wdata=8'hA5; bench peripheral ACKs both slots. Required: START seen, address bits 0,1,0,0,0,0,1 then rw 0, data bits 1,0,1,0,0,1,0,1, STOP; done pulses once; ack_error=0.
- Read: addr=7'h42, rw=1; peripheral sends 8'h3C LSB-first. Required: rdata=8'h3C at done; SDA driven low in 9th clock; STOP follows.
- Address NACK: addr=7'h11, no device responding (SDA pulled up). Required: no data clocks after the AACK bit; STOP; done with ack_error=1.
- Busy ignore: pulse start, then pulse start again with wdata=8'hFF mid-transaction. Required: only the first byte is transmitted; exactly one done pulse.
- Reset mid-operation: assert reset_n=0 during WDATA bit 3. Required: scl=z and sda=z in the same cycle; busy=0; done not pulsed; a fresh start afterwards completes normally.
- Back-to-back: start held high continuously through two transactions. Required: second START occurs no earlier than one cycle after the first done; both bytes are correct.

Source files
------------

// File: rtl/i2c_controller.sv
// Single-byte I2C controller: START, 7-bit address + R/W, one data byte, STOP.
// Open-drain SCL/SDA with LSB-first framing matching the i2c_peripheral slaves.
module i2c_controller #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    inout  wire        scl,
    inout  wire        sda
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_AACK,
        S_WDATA,
        S_WACK,
        S_RDATA,
        S_RACK,
        S_STOP
    } state_e;

    localparam int unsigned   QW   = $clog2(CLK_DIV);
    localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);

    state_e        state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [2:0]    bit_q, bit_d;
    logic [6:0]    addr_q, addr_d;
    logic          rw_q, rw_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ack_err_q, ack_err_d;
    logic          sda_meta_q, sda_sync_q;

    logic          tick;
    logic [7:0]    frame;
    logic          scl_low, sda_low;

    assign tick  = busy_q && (qcnt_q == QMAX);
    assign frame = {rw_q, addr_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            qcnt_q     <= '0;
            qtr_q      <= '0;
            bit_q      <= '0;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            qcnt_q     <= qcnt_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ack_err_q  <= ack_err_d;
            sda_meta_q <= sda;
            sda_sync_q <= sda_meta_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;
        qcnt_d    = (busy_q && !tick) ? qcnt_q + QW'(1) : '0;

        case (state_q)
            S_IDLE: begin
                // done_q blocks a start held across the completion cycle
                if (start && !busy_q && !done_q) begin
                    addr_d    = addr;
                    rw_d      = rw;
                    wdata_d   = wdata;
                    ack_err_d = 1'b0;
                    busy_d    = 1'b1;
                    qtr_d     = '0;
                    bit_d     = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (qtr_q == 2'd2) begin
                        qtr_d   = '0;
                        state_d = S_ADDR;
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    // Q2->Q3 boundary is the sample point for every released-SDA bit
                    if (qtr_q == 2'd2) begin
                        if ((state_q == S_AACK || state_q == S_WACK) && sda_sync_q)
                            ack_err_d = 1'b1;
                        if (state_q == S_RDATA)
                            rdata_d[bit_q] = sda_sync_q;
                    end
                    if (qtr_q == 2'd3) begin
                        case (state_q)
                            S_ADDR: begin
                                bit_d = bit_q + 3'd1;
                                if (bit_q == 3'd7) state_d = S_AACK;
                            end
                            S_AACK:  state_d = ack_err_q ? S_STOP : (rw_q ? S_RDATA : S_WDATA);
                            S_WDATA: begin
                                bit_d = bit_q + 3'd1;
                                if (bit_q == 3'd7) state_d = S_WACK;
                            end
                            S_RDATA: begin
                                bit_d = bit_q + 3'd1;
                                if (bit_q == 3'd7) state_d = S_RACK;
                            end
                            S_WACK:  state_d = S_STOP;
                            S_RACK:  state_d = S_STOP;
                            default: state_d = S_IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    always_comb begin
        scl_low = 1'b0;
        sda_low = 1'b0;
        case (state_q)
            S_START: sda_low = (qtr_q != 2'd0);
            S_ADDR: begin
                scl_low = ~qtr_q[1];
                sda_low = ~frame[bit_q];
            end
            S_WDATA: begin
                scl_low = ~qtr_q[1];
                sda_low = ~wdata_q[bit_q];
            end
            S_AACK, S_WACK, S_RDATA: scl_low = ~qtr_q[1];
            S_RACK: begin
                scl_low = ~qtr_q[1];
                sda_low = 1'b1;
            end
            S_STOP: begin
                scl_low = (qtr_q == 2'd0);
                sda_low = ~qtr_q[1];
            end
            default: ;
        endcase
    end

    assign scl       = scl_low ? 1'b0 : 1'bz;
    assign sda       = sda_low ? 1'b0 : 1'bz;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ack_error = ack_err_q;

endmodule

// File: tb/tb_i2c_controller.sv
// Scoreboard bench for i2c_controller: a bus-level peripheral model records every
// SCL-high SDA value; a monitor pops expected transactions on each done pulse.
module tb_i2c_controller;

    localparam int unsigned CLK_DIV     = 2;
    localparam logic [6:0]  DEV_ADDR    = 7'h42;
    localparam logic [7:0]  PERIPH_BYTE = 8'h3C;

    typedef struct {
        logic        nack;
        logic [7:0]  frame;
        logic [7:0]  data;
        logic [7:0]  rdata;
        int unsigned rises;
        int unsigned lat;
        int unsigned acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n, start, rw;
    logic [6:0]  addr;
    logic [7:0]  wdata, rdata;
    logic        busy, done, ack_error;
    wire         scl, sda;
    logic        p_sda_low = 1'b0;

    pullup (scl);
    pullup (sda);
    assign sda = p_sda_low ? 1'b0 : 1'bz;

    i2c_controller #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .addr      (addr),
        .rw        (rw),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy),
        .done      (done),
        .ack_error (ack_error),
        .scl       (scl),
        .sda       (sda)
    );

    always #5 clk = ~clk;

    exp_t        sbq[$];
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned done_cnt = 0;
    int unsigned cyc = 0;
    logic [7:0]  model_rdata = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    endtask

    task automatic chk_win(input string nm, input int unsigned act, input int unsigned lo, input int unsigned hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, required %0d..%0d", nm, act, lo, hi);
    endtask

    // Bus-level peripheral model at DEV_ADDR: records SDA at each SCL rise,
    // acknowledges address/write data and returns PERIPH_BYTE on reads.
    logic        prev_scl = 1'b1;
    logic        prev_sda = 1'b1;
    logic [19:0] seen = '0;
    int unsigned rises = 0;
    logic        stop_seen = 1'b0;
    logic [7:0]  tx_byte = PERIPH_BYTE;

    always @(negedge clk) begin : periph
        logic cs, cd, hit;
        cs  = (scl === 1'b1);
        cd  = (sda === 1'b1);
        hit = (seen[6:0] == DEV_ADDR);
        if (!reset_n) begin
            p_sda_low = 1'b0;
        end else if (prev_scl && cs && prev_sda && !cd) begin
            rises     = 0;
            seen      = '0;
            stop_seen = 1'b0;
        end else if (prev_scl && cs && !prev_sda && cd) begin
            stop_seen = 1'b1;
        end else if (!prev_scl && cs) begin
            if (rises < 20) seen[rises[4:0]] = cd;
            rises++;
        end else if (prev_scl && !cs) begin
            p_sda_low = 1'b0;
            if (rises == 8) p_sda_low = hit;
            else if (rises >= 9 && rises <= 16) p_sda_low = hit && seen[7] && !tx_byte[3'(rises - 9)];
            else if (rises == 17) p_sda_low = hit && !seen[7];
        end
        prev_scl = cs;
        prev_sda = cd;
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n && done) begin
            done_cnt++;
            if (sbq.size() == 0) begin
                chk("done_expected", 32'(done), 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("frame", 32'(seen[7:0]), 32'(e.frame));
                chk("aack_bit", 32'(seen[8]), 32'(e.nack));
                if (!e.nack) begin
                    chk("data_bits", 32'(seen[16:9]), 32'(e.data));
                    chk("ninth_ack", 32'(seen[17]), 32'd0);
                end
                chk("clock_count", rises, e.rises);
                chk("stop_seen", 32'(stop_seen), 32'd1);
                chk("ack_error", 32'(ack_error), 32'(e.nack));
                chk("rdata", 32'(rdata), 32'(e.rdata));
                chk("busy_at_done", 32'(busy), 32'd0);
                chk_win("latency", cyc - e.acc, e.lat - CLK_DIV, e.lat + CLK_DIV);
            end
        end
    end

    function automatic exp_t make_exp(input logic [6:0] a, input logic r, input logic [7:0] d,
                                      input int unsigned acc);
        exp_t e;
        e.nack  = (a != DEV_ADDR);
        e.frame = {r, a};
        e.data  = r ? PERIPH_BYTE : d;
        if (r && !e.nack) model_rdata = PERIPH_BYTE;
        e.rdata = model_rdata;
        e.rises = e.nack ? 10 : 19;
        e.lat   = (e.nack ? 43 : 79) * CLK_DIV;
        e.acc   = acc;
        return e;
    endfunction

    task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] d, input bit push);
        int unsigned acc;
        @(negedge clk);
        addr  = a;
        rw    = r;
        wdata = d;
        start = 1'b1;
        @(posedge clk);
        #1 acc = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("accept_busy", 32'(busy), 32'd1);
        if (push) sbq.push_back(make_exp(a, r, d, acc));
    endtask

    task automatic wait_done(input string nm);
        int unsigned i = 0;
        while (i < 600 && done !== 1'b1) begin
            @(negedge clk);
            i++;
        end
        chk({nm, "_done_seen"}, 32'(done), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int unsigned acc;
        reset_n = 1'b0;
        start   = 1'b0;
        addr    = '0;
        rw      = 1'b0;
        wdata   = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ack_error", 32'(ack_error), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'h00);
        chk("rst_scl", 32'(scl), 32'd1);
        chk("rst_sda", 32'(sda), 32'd1);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        issue(DEV_ADDR, 1'b0, 8'hA5, 1'b1);
        wait_done("write");
        issue(DEV_ADDR, 1'b1, 8'h00, 1'b1);
        wait_done("read");
        issue(7'h11, 1'b1, 8'h00, 1'b1);
        wait_done("nack");

        // second start mid-transaction must be ignored
        issue(DEV_ADDR, 1'b0, 8'h5A, 1'b1);
        repeat (40) @(negedge clk);
        chk("ignore_busy", 32'(busy), 32'd1);
        addr  = 7'h11;
        rw    = 1'b1;
        wdata = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore");
        repeat (20) @(negedge clk);
        chk("ignore_single_done", done_cnt, 32'd4);

        // abort during data bit 3 (clock 12)
        issue(DEV_ADDR, 1'b0, 8'hA5, 1'b0);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 400 && rises != 12; i++) @(posedge clk);
        repeat (4) @(negedge clk);
        chk("pre_reset_sda", 32'(sda), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("abort_scl", 32'(scl), 32'd1);
        chk("abort_sda", 32'(sda), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        model_rdata = 8'h00;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("abort_no_done", done_cnt, 32'd4);

        issue(DEV_ADDR, 1'b0, 8'hC3, 1'b1);
        wait_done("fresh");

        // start held high across two transactions
        @(negedge clk);
        addr  = DEV_ADDR;
        rw    = 1'b0;
        wdata = 8'h96;
        start = 1'b1;
        @(posedge clk);
        #1 acc = cyc;
        sbq.push_back(make_exp(DEV_ADDR, 1'b0, 8'h96, acc));
        @(negedge clk);
        chk("b2b_busy1", 32'(busy), 32'd1);
        wdata = 8'h69;
        wait_done("b2b1");
        @(negedge clk);
        chk("b2b_gap_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 acc = cyc;
        sbq.push_back(make_exp(DEV_ADDR, 1'b0, 8'h69, acc));
        @(negedge clk);
        chk("b2b_busy2", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done("b2b2");

        repeat (10) @(negedge clk);
        chk("done_count", done_cnt, 32'd7);
        chk("scoreboard_empty", sbq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
